// File: rtl/wb_stage_if.sv
// Writeback stage bus: memory-stage handoff, data-memory response,
// register-file write port and sticky error flags.
interface wb_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic            in_reg_we;
   logic [1:0]      in_reg_sel;
   logic [2:0]      in_load_sel;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_result;
   logic [XLEN-1:0] in_pc_plus_4;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            retire;
   logic            err_misalign;
   logic            err_timeout;
   logic            err_spurious;

   modport master (
      output in_valid, in_reg_we, in_reg_sel, in_load_sel,
      output in_rd, in_result, in_pc_plus_4,
      output mem_rvalid, mem_rdata,
      input  in_ready, rf_we, rf_waddr, rf_wdata, retire,
      input  err_misalign, err_timeout, err_spurious
   );

   modport slave (
      input  in_valid, in_reg_we, in_reg_sel, in_load_sel,
      input  in_rd, in_result, in_pc_plus_4,
      input  mem_rvalid, mem_rdata,
      output in_ready, rf_we, rf_waddr, rf_wdata, retire,
      output err_misalign, err_timeout, err_spurious
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects result, waits on load response, aligns and
// extends loaded data, and issues a registered register-file write.
module wb_stage #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int XLEN           = 32
) (
   input logic    clock,
   input logic    reset_n,
   wb_stage_if.slave bus
);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [4:0]      rd_q, rd_d;
   logic [2:0]      sel_q, sel_d;
   logic [1:0]      lo_q, lo_d;
   logic            we_q, we_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            retire_q, retire_d;
   logic            mis_q, mis_d;
   logic            to_q, to_d;
   logic            sp_q, sp_d;

   logic            bad_load;
   logic [7:0]      b_v;
   logic [15:0]     h_v;
   logic [XLEN-1:0] ext_v;

   // misaligned or illegal load, judged on the incoming request
   always_comb begin
      bad_load = 1'b0;
      case (bus.in_load_sel)
         3'd0:    bad_load = (bus.in_result[1:0] != 2'd0);
         3'd1,
         3'd2:    bad_load = bus.in_result[0];
         3'd3,
         3'd4:    bad_load = 1'b0;
         default: bad_load = 1'b1;
      endcase
   end

   assign b_v = bus.mem_rdata[{lo_q, 3'b000} +: 8];
   assign h_v = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

   always_comb begin
      ext_v = bus.mem_rdata;
      case (sel_q)
         3'd1:    ext_v = {{16{h_v[15]}}, h_v};
         3'd2:    ext_v = {16'h0000, h_v};
         3'd3:    ext_v = {{24{b_v[7]}}, b_v};
         3'd4:    ext_v = {24'h000000, b_v};
         default: ext_v = bus.mem_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      sel_d    = sel_q;
      lo_d     = lo_q;
      we_d     = we_q;
      rf_we_d  = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      retire_d = 1'b0;
      mis_d    = mis_q;
      to_d     = to_q;
      sp_d     = sp_q;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_rvalid) sp_d = 1'b1;
            if (bus.in_valid) begin
               if (bus.in_reg_sel == 2'd1) begin
                  rd_d  = bus.in_rd;
                  sel_d = bus.in_load_sel;
                  lo_d  = bus.in_result[1:0];
                  we_d  = bus.in_reg_we;
                  if (bad_load) begin
                     retire_d = 1'b1;
                     mis_d    = 1'b1;
                  end else begin
                     state_d = WAIT_MEM;
                     cnt_d   = 8'd0;
                  end
               end else begin
                  retire_d = 1'b1;
                  rf_we_d  = bus.in_reg_we && (bus.in_rd != 5'd0);
                  if (rf_we_d) begin
                     waddr_d = bus.in_rd;
                     wdata_d = (bus.in_reg_sel == 2'd2) ?
                               bus.in_pc_plus_4 : bus.in_result;
                  end
               end
            end
         end
         WAIT_MEM: begin
            // a response in the final cycle still wins over the timeout
            if (bus.mem_rvalid) begin
               state_d  = IDLE;
               retire_d = 1'b1;
               rf_we_d  = we_q && (rd_q != 5'd0);
               if (rf_we_d) begin
                  waddr_d = rd_q;
                  wdata_d = ext_v;
               end
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               state_d  = IDLE;
               retire_d = 1'b1;
               to_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rd_q     <= '0;
         sel_q    <= '0;
         lo_q     <= '0;
         we_q     <= 1'b0;
         rf_we_q  <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         retire_q <= 1'b0;
         mis_q    <= 1'b0;
         to_q     <= 1'b0;
         sp_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         sel_q    <= sel_d;
         lo_q     <= lo_d;
         we_q     <= we_d;
         rf_we_q  <= rf_we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         retire_q <= retire_d;
         mis_q    <= mis_d;
         to_q     <= to_d;
         sp_q     <= sp_d;
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.rf_we        = rf_we_q;
   assign bus.rf_waddr     = waddr_q;
   assign bus.rf_wdata     = wdata_q;
   assign bus.retire       = retire_q;
   assign bus.err_misalign = mis_q;
   assign bus.err_timeout  = to_q;
   assign bus.err_spurious = sp_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed transactions, a transaction-level
// reference model checked every cycle, and literal spot checks.
module tb_wb_stage;

   localparam int TO = 16;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   wb_stage_if #(.XLEN(32)) bus ();

   wb_stage #(.TIMEOUT_CYCLES(TO), .XLEN(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a pending load plus the outputs it implies
   bit          m_busy = 0;
   int          m_cnt  = 0;
   logic [4:0]  m_rd   = 0;
   logic [2:0]  m_lsel = 0;
   logic [1:0]  m_lo   = 0;
   bit          m_we   = 0;
   bit          e_we = 0, e_ret = 0, e_mis = 0, e_to = 0, e_sp = 0;
   logic [4:0]  e_addr = 0;
   logic [31:0] e_data = 0;

   function automatic logic [31:0] load_value(input logic [2:0] lsel,
      input logic [1:0] lo, input logic [31:0] word);
      logic [31:0] b, h;
      b = word >> (8 * lo);
      h = word >> (16 * (lo / 2));
      case (lsel)
         3'd1:    return 32'($signed(h[15:0]));
         3'd2:    return {16'd0, h[15:0]};
         3'd3:    return 32'($signed(b[7:0]));
         3'd4:    return {24'd0, b[7:0]};
         default: return word;
      endcase
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 0; m_cnt = 0;
         e_we = 0; e_ret = 0; e_mis = 0; e_to = 0; e_sp = 0;
         e_addr = 0; e_data = 0;
      end else begin
         e_we = 0; e_ret = 0;
         if (m_busy) begin
            if (bus.mem_rvalid) begin
               m_busy = 0; e_ret = 1;
               if (m_we && m_rd != 0) begin
                  e_we = 1; e_addr = m_rd;
                  e_data = load_value(m_lsel, m_lo, bus.mem_rdata);
               end
            end else begin
               m_cnt++;
               if (m_cnt == TO) begin
                  m_busy = 0; e_ret = 1; e_to = 1;
               end
            end
         end else begin
            if (bus.mem_rvalid) e_sp = 1;
            if (bus.in_valid) begin
               if (bus.in_reg_sel == 2'd1) begin
                  logic [1:0] lo;
                  logic [2:0] ls;
                  bit bad;
                  lo = bus.in_result[1:0];
                  ls = bus.in_load_sel;
                  bad = (ls > 4) || (ls == 0 && lo != 0) ||
                        ((ls == 1 || ls == 2) && (lo % 2 == 1));
                  if (bad) begin
                     e_ret = 1; e_mis = 1;
                  end else begin
                     m_busy = 1; m_cnt = 0;
                     m_rd = bus.in_rd; m_lsel = ls; m_lo = lo;
                     m_we = bus.in_reg_we;
                  end
               end else begin
                  e_ret = 1;
                  if (bus.in_reg_we && bus.in_rd != 0) begin
                     e_we = 1; e_addr = bus.in_rd;
                     e_data = (bus.in_reg_sel == 2'd2) ?
                              bus.in_pc_plus_4 : bus.in_result;
                  end
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         chk("in_ready", 32'(bus.in_ready), 32'(!m_busy));
         chk("rf_we", 32'(bus.rf_we), 32'(e_we));
         chk("rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
         chk("rf_wdata", bus.rf_wdata, e_data);
         chk("retire", 32'(bus.retire), 32'(e_ret));
         chk("err_misalign", 32'(bus.err_misalign), 32'(e_mis));
         chk("err_timeout", 32'(bus.err_timeout), 32'(e_to));
         chk("err_spurious", 32'(bus.err_spurious), 32'(e_sp));
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sel,
      input logic [2:0] lsel, input logic [4:0] rd,
      input logic [31:0] res, input logic [31:0] pc4);
      bus.in_valid     = 1'b1;
      bus.in_reg_we    = we;
      bus.in_reg_sel   = sel;
      bus.in_load_sel  = lsel;
      bus.in_rd        = rd;
      bus.in_result    = res;
      bus.in_pc_plus_4 = pc4;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic resp(input logic [31:0] data, input int delay);
      repeat (delay) step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = data;
      step();
      bus.mem_rvalid = 1'b0;
   endtask

   initial begin
      bus.in_valid     = 0;
      bus.in_reg_we    = 0;
      bus.in_reg_sel   = 0;
      bus.in_load_sel  = 0;
      bus.in_rd        = 0;
      bus.in_result    = 0;
      bus.in_pc_plus_4 = 0;
      bus.mem_rvalid   = 0;
      bus.mem_rdata    = 0;
      repeat (2) step();
      reset_n = 1'b1;
      #1;
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst rf_wdata", bus.rf_wdata, 32'd0);
      step();

      // ALU result
      issue(1, 2'd0, 3'd0, 5'd5, 32'h1234_5678, 32'h0);
      chk("alu rf_we", 32'(bus.rf_we), 32'd1);
      chk("alu waddr", 32'(bus.rf_waddr), 32'd5);
      chk("alu wdata", bus.rf_wdata, 32'h1234_5678);
      chk("alu ready", 32'(bus.in_ready), 32'd1);

      // back-to-back: JAL link then reg_sel=3 as result
      bus.in_valid = 1; bus.in_reg_we = 1; bus.in_reg_sel = 2'd2;
      bus.in_rd = 5'd1; bus.in_result = 32'hAAAA_0000;
      bus.in_pc_plus_4 = 32'h0000_1004;
      step();
      chk("jal wdata", bus.rf_wdata, 32'h0000_1004);
      bus.in_reg_sel = 2'd3; bus.in_rd = 5'd2;
      step();
      bus.in_valid = 0;
      chk("sel3 wdata", bus.rf_wdata, 32'hAAAA_0000);
      step();

      // LOAD_B, addr_lo=3, response after 3 empty cycles
      issue(1, 2'd1, 3'd3, 5'd7, 32'h0000_1003, 32'h0);
      resp(32'h80FF_0000, 3);
      chk("lb wdata", bus.rf_wdata, 32'hFFFF_FF80);
      chk("lb rf_we", 32'(bus.rf_we), 32'd1);

      issue(1, 2'd1, 3'd2, 5'd8, 32'h0000_2002, 32'h0);
      resp(32'h8001_1234, 1);
      chk("lhu wdata", bus.rf_wdata, 32'h0000_8001);
      issue(1, 2'd1, 3'd1, 5'd9, 32'h0000_2002, 32'h0);
      resp(32'h8001_1234, 0);
      chk("lh wdata", bus.rf_wdata, 32'hFFFF_8001);
      issue(1, 2'd1, 3'd0, 5'd10, 32'h0000_2000, 32'h0);
      resp(32'h8001_1234, 2);
      chk("lw wdata", bus.rf_wdata, 32'h8001_1234);
      issue(1, 2'd1, 3'd4, 5'd11, 32'h0000_2001, 32'h0);
      resp(32'h0000_9C00, 0);
      chk("lbu wdata", bus.rf_wdata, 32'h0000_009C);

      // response in the last allowed cycle is honoured
      issue(1, 2'd1, 3'd0, 5'd12, 32'h0, 32'h0);
      resp(32'hCAFE_F00D, TO - 1);
      chk("late wdata", bus.rf_wdata, 32'hCAFE_F00D);
      chk("late no to", 32'(bus.err_timeout), 32'd0);

      // suppressed writes
      issue(1, 2'd2, 3'd0, 5'd0, 32'h0, 32'h0000_0040);
      chk("rd0 retire", 32'(bus.retire), 32'd1);
      chk("rd0 rf_we", 32'(bus.rf_we), 32'd0);
      issue(1, 2'd1, 3'd0, 5'd13, 32'h0000_0002, 32'h0);
      chk("mis flag", 32'(bus.err_misalign), 32'd1);
      chk("mis ready", 32'(bus.in_ready), 32'd1);
      chk("mis rf_we", 32'(bus.rf_we), 32'd0);
      issue(1, 2'd1, 3'd6, 5'd13, 32'h0, 32'h0);
      issue(0, 2'd1, 3'd0, 5'd14, 32'h0, 32'h0);
      resp(32'h1111_1111, 1);
      chk("noweload", 32'(bus.rf_we), 32'd0);

      // timeout, then stray response
      issue(1, 2'd1, 3'd0, 5'd15, 32'h0, 32'h0);
      repeat (TO) step();
      chk("to flag", 32'(bus.err_timeout), 32'd1);
      chk("to ready", 32'(bus.in_ready), 32'd1);
      chk("to rf_we", 32'(bus.rf_we), 32'd0);
      resp(32'h2222_2222, 1);
      chk("spur flag", 32'(bus.err_spurious), 32'd1);

      // reset while waiting
      issue(1, 2'd1, 3'd0, 5'd16, 32'h0, 32'h0);
      step();
      step();
      reset_n = 1'b0;
      #1;
      chk("arst mis", 32'(bus.err_misalign), 32'd0);
      chk("arst to", 32'(bus.err_timeout), 32'd0);
      chk("arst sp", 32'(bus.err_spurious), 32'd0);
      chk("arst waddr", 32'(bus.rf_waddr), 32'd0);
      chk("arst wdata", bus.rf_wdata, 32'd0);
      chk("arst ready", 32'(bus.in_ready), 32'd1);
      step();
      reset_n = 1'b1;
      step();
      resp(32'h3333_3333, 1);
      chk("post rf_we", 32'(bus.rf_we), 32'd0);
      chk("post spur", 32'(bus.err_spurious), 32'd1);
      step();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
